// File: rtl/multicycle_controller.sv
// multicycle_controller: main sequencing FSM for the multicycle RV32I core.
// Steps each instruction through fetch/decode/execute/memory/writeback, drives
// the datapath selects and write enables, and supervises the memory handshake
// with a bounded wait. Optional performance counters are built only when the
// CTRL_PERF_CNT_EN macro is defined.
module multicycle_controller #(
  parameter int MEM_TMO = 255
`ifdef CTRL_PERF_CNT_EN
  , parameter int PERF_W = 32
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [6:0]        op,
  input  logic [2:0]        funct3,
  input  logic              zero,
  input  logic              mem_ready,
  output logic              pc_write,
  output logic              adr_src,
  output logic              mem_write,
  output logic              ir_write,
  output logic [1:0]        result_src,
  output logic [1:0]        alu_src_a,
  output logic [1:0]        alu_src_b,
  output logic [1:0]        alu_op,
  output logic              reg_write,
  output logic              illegal_instr,
  output logic              mem_timeout
`ifdef CTRL_PERF_CNT_EN
  , output logic [PERF_W-1:0] perf_cycles,
  output logic [PERF_W-1:0] perf_instret
`endif
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // The wait counter fires on the cycle that would make it reach MEM_TMO.
  localparam logic [7:0] TMO_LAST = 8'(MEM_TMO - 1);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] wait_cnt;
  logic       in_wait;
  logic       tmo_hit;

  // Only beq/bne are decoded, so just funct3[0] matters.
  logic unused_funct3;
  assign unused_funct3 = ^funct3[2:1];

  assign in_wait = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
  assign tmo_hit = in_wait && !mem_ready && (wait_cnt == TMO_LAST);

  // State register, memory wait counter and sticky timeout flag.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_FETCH;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state <= state_nxt;
      if (tmo_hit) mem_timeout <= 1'b1;
      // Wait states are only left on mem_ready or a timeout, both of which clear.
      if (in_wait && !mem_ready && !tmo_hit) wait_cnt <= wait_cnt + 8'd1;
      else                                   wait_cnt <= '0;
    end
  end

  // Next-state logic and Moore output decode (FETCH/BRANCH also look at inputs).
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    state_nxt     = state;
    pc_write      = 1'b0;
    adr_src       = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    result_src    = 2'b00;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    reg_write     = 1'b0;
    illegal_instr = 1'b0;
    case (state)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        if (mem_ready) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: state_nxt = S_MEMADR;
          OP_RTYPE:          state_nxt = S_EXECR;
          OP_ITYPE:          state_nxt = S_EXECI;
          OP_BRANCH:         state_nxt = S_BRANCH;
          OP_JAL:            state_nxt = S_JAL;
          default: begin
            illegal_instr = 1'b1;
            state_nxt     = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_nxt = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (mem_ready) state_nxt = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) state_nxt = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_nxt = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        state_nxt = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        state_nxt = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        pc_write  = zero ^ funct3[0];
        state_nxt = S_FETCH;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
        state_nxt = S_ALUWB;
      end
      default: state_nxt = S_FETCH;
    endcase
    // An abandoned access always restarts at FETCH.
    if (tmo_hit) state_nxt = S_FETCH;
  end

`ifdef CTRL_PERF_CNT_EN
  // Free-running cycle counter and retired-instruction counter (FETCH->DECODE).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cycles  <= '0;
      perf_instret <= '0;
    end else begin
      perf_cycles <= perf_cycles + PERF_W'(1);
      if (state == S_FETCH && mem_ready) perf_instret <= perf_instret + PERF_W'(1);
    end
  end
`endif

endmodule
